// File: rtl/wiener_block_burst_serializer.sv
// wiener_block_burst_serializer
// Buffers Wiener-filtered pixels from an AXI-stream slave in a FIFO and
// replays them as BLOCK_SIZE-pixel write bursts for memory_writer_output.
// Each burst has three parts: a one-cycle start pulse, then SETUP_CYCLES idle
// cycles, then one pixel per accepted wvalid beat. Pops are counted against
// pixels_per_frame, and frame_done pulses once per completed frame.
//
// Optional feature macro: SER_STATS_EN. When it is defined, the block adds
// the burst_count and stall_seen outputs.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pixels_per_frame  pixels per frame; latched while IDLE; 0 disables frame_done
//   s_axis_tdata/tvalid/tready  pixel stream in
//   wvalid            downstream accepted a write-data beat; advances the burst
//   start_write_out   one-cycle burst start pulse
//   data_out          current burst pixel (holds its last value outside BURST)
//   busy              FSM not IDLE
//   frame_done        one-cycle pulse after the last pixel of a frame is popped
//   burst_count       (SER_STATS_EN) saturating count of bursts started
//   stall_seen        (SER_STATS_EN) sticky: wvalid was low during a BURST cycle
module wiener_block_burst_serializer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pixels_per_frame,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  wvalid,
  output logic                  start_write_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done
`ifdef SER_STATS_EN
  ,
  output logic [31:0]           burst_count,
  output logic                  stall_seen
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BLOCK_SIZE) + 1;
  localparam int SET_W  = $clog2(SETUP_CYCLES) + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BLK_C      = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BLOCK_SIZE - 1);
  localparam logic [SET_W-1:0]  SET_ONE    = SET_W'(1);
  localparam logic [SET_W-1:0]  SETUP_LOAD = SET_W'(SETUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, SETUP, BURST} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  tready_r;
  logic [SET_W-1:0]      setup_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  start_r;
  logic [DATA_WIDTH-1:0] data_hold;
  logic [31:0]           ppf_lat;
  logic [31:0]           frame_cnt;
  logic                  frame_done_r;
  logic                  push, pop;

  // The pointers wrap for free because FIFO_DEPTH is a power of two. BURST is
  // only entered with at least BLOCK_SIZE entries stored, so a pop never
  // underflows.
  assign push = s_axis_tvalid && tready_r;
  assign pop  = (state == BURST) && wvalid;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_ONE;
    else if (!push && pop) count_next = count - CNT_ONE;
  end

  // FIFO storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

  // FIFO control. tready is registered from the next occupancy, so it stays
  // low for the whole time reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tready_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      tready_r <= (count_next < DEPTH_C);
    end
  end

  // Burst FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      setup_cnt <= '0;
      beat_cnt  <= '0;
      start_r   <= 1'b0;
      data_hold <= '0;
    end else begin
      // Follow the head during BURST so data_out keeps the last popped pixel afterwards.
      if (state == BURST) data_hold <= mem[rd_ptr];
      case (state)
        IDLE: begin
          if (count >= BLK_C) begin
            state   <= START;
            start_r <= 1'b1;
          end
        end
        START: begin
          start_r   <= 1'b0;
          setup_cnt <= SETUP_LOAD;
          state     <= SETUP;
        end
        SETUP: begin
          if (setup_cnt == '0) begin
            state    <= BURST;
            beat_cnt <= '0;
          end else begin
            setup_cnt <= setup_cnt - SET_ONE;
          end
        end
        BURST: begin
          if (wvalid) begin
            if (beat_cnt == BEAT_LAST) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame tracking. pixels_per_frame is latched only while IDLE, so a change
  // mid-burst takes effect at the next burst boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppf_lat      <= '0;
      frame_cnt    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      if (state == IDLE) ppf_lat <= pixels_per_frame;
      frame_done_r <= 1'b0;
      if (pop) begin
        if ((ppf_lat != 32'd0) && (frame_cnt == ppf_lat - 32'd1)) begin
          frame_cnt    <= '0;
          frame_done_r <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 32'd1;
        end
      end
    end
  end

`ifdef SER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_count <= '0;
      stall_seen  <= 1'b0;
    end else begin
      if ((state == START) && (burst_count != 32'hFFFF_FFFF))
        burst_count <= burst_count + 32'd1;
      if ((state == BURST) && !wvalid) stall_seen <= 1'b1;
    end
  end
`endif

  assign s_axis_tready   = tready_r;
  assign start_write_out = start_r;
  assign busy            = (state != IDLE);
  assign frame_done      = frame_done_r;
  assign data_out        = (state == BURST) ? mem[rd_ptr] : data_hold;

endmodule

// File: tb/tb_wiener_block_burst_serializer.sv
module tb_wiener_block_burst_serializer;
  localparam int DW = 32;
  localparam int BS = 8;
  localparam int FD = 16;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pixels_per_frame;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          wvalid;
  logic          start_write_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          frame_done;
`ifdef SER_STATS_EN
  logic [31:0]   burst_count;
  logic          stall_seen;
`endif

  always #5 clk = ~clk;

  wiener_block_burst_serializer #(
    .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .FIFO_DEPTH(FD), .SETUP_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixels_per_frame(pixels_per_frame),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .wvalid(wvalid),
    .start_write_out(start_write_out), .data_out(data_out),
    .busy(busy), .frame_done(frame_done)
`ifdef SER_STATS_EN
    , .burst_count(burst_count), .stall_seen(stall_seen)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] ppf = 32'd0;

  // Monitor state
  int   n_starts = 0, n_fd = 0, beats_done = 0;
  int   since = 0, left = 0, pops_tb = 0;
  logic mon_act = 1'b0, exp_fd = 1'b0, chk_idle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: follows the burst protocol. After a start pulse, a beat is
  // presented on every wvalid=1 cycle that falls SC+1 or more cycles after
  // the pulse, until BS beats have been seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0; since = 0; left = 0; pops_tb = 0;
      exp_fd = 1'b0; chk_idle = 1'b0; n_starts = 0; n_fd = 0; beats_done = 0;
    end else begin
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      exp_fd = 1'b0;
      if (frame_done) n_fd++;
      if (chk_idle) begin
        chk("busy_after_burst", {31'd0, busy}, 32'd0);
        chk_idle = 1'b0;
      end
      if (start_write_out) begin
        chk("start_while_active", {31'd0, mon_act}, 32'd0);
        n_starts++;
        mon_act = 1'b1; since = 0; left = BS;
      end else if (mon_act) begin
        since++;
        if (since >= SC + 1 && wvalid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got beat %h, want no beat", data_out);
          end else begin
            chk("data_out", data_out, q.pop_front());
          end
          chk("busy_in_burst", {31'd0, busy}, 32'd1);
          beats_done++; left--; pops_tb++;
          if (ppf != 0 && pops_tb == ppf) begin
            exp_fd = 1'b1; pops_tb = 0;
          end
          if (left == 0) begin
            mon_act = 1'b0; chk_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] v);
    int n = 0;
    @(posedge clk); #1;
    s_axis_tdata = v; s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 1000) begin
        checks++; errors++;
        $display("FAIL push_timeout: got tready 0, want 1");
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    q.push_back(v);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() >= BS || busy || mon_act) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got busy %0d queued %0d, want idle", busy, q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] v1 [8] = '{32'h2E, 32'h12, 32'hFD, 32'hB4, 32'h7C, 32'h60, 32'h58, 32'h31};

  initial begin
    int base;
    int n;
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; wvalid = 1'b0;
    pixels_per_frame = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_start", {31'd0, start_write_out}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);

    // Single burst, wvalid held high
    @(posedge clk); #1 wvalid = 1'b1;
    base = n_starts;
    for (int i = 0; i < 8; i++) push(v1[i]);
    drain();
    chk("t1_starts", n_starts - base, 32'd1);
    chk("t1_data_hold", data_out, 32'h31);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Seven pixels: no burst; the eighth triggers START
    base = n_starts;
    for (int i = 0; i < 7; i++) push(32'hA0 + i);
    repeat (20) @(negedge clk);
    chk("t2_no_start", n_starts - base, 32'd0);
    chk("t2_idle", {31'd0, busy}, 32'd0);
    push(32'hA7);
    @(negedge clk);
    @(negedge clk);
    chk("t2_start_next", {31'd0, start_write_out}, 32'd1);
    drain();

    // Stalled burst fills the FIFO
    @(posedge clk); #1 wvalid = 1'b0;
    base = n_starts;
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    @(negedge clk);
    chk("t3_full_tready", {31'd0, s_axis_tready}, 32'd0);
    fork
      begin
        for (int i = 16; i < 20; i++) push(32'h100 + i);
      end
      begin
        repeat (10) @(negedge clk);
        chk("t3_still_full", {31'd0, s_axis_tready}, 32'd0);
        chk("t3_one_start", n_starts - base, 32'd1);
        @(posedge clk); #1 wvalid = 1'b1;
      end
    join
    for (int i = 20; i < 24; i++) push(32'h100 + i);
    drain();
    chk("t3_starts", n_starts - base, 32'd3);
    chk("t3_empty", q.size(), 32'd0);

    // Reset asserted in the middle of a burst
    base = beats_done;
    for (int i = 0; i < 8; i++) push(32'h200 + i);
    n = 0;
    while (beats_done - base < 3 && n < 200) begin
      @(posedge clk); n++;
    end
    chk("t5_reached_beat3", {31'd0, (beats_done - base >= 3)}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_start", {31'd0, start_write_out}, 32'd0);
    chk("t5_data", data_out, 32'd0);
    chk("t5_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("t5_frame_done", {31'd0, frame_done}, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h300 + i);
    drain();
    chk("t5_fresh_starts", n_starts, 32'd1);

    // Two 256-pixel frames
    ppf = 32'd256; pixels_per_frame = 32'd256;
    do_reset();
    for (int i = 0; i < 256; i++) push((i * 37 + 11) & 32'hFFFF);
    drain();
    chk("t4_starts_f1", n_starts, 32'd32);
    chk("t4_fd_f1", n_fd, 32'd1);
    for (int i = 0; i < 256; i++) push((i * 53 + 5) & 32'hFFFF);
    drain();
    chk("t4_starts_f2", n_starts, 32'd64);
    chk("t4_fd_f2", n_fd, 32'd2);
    ppf = 32'd0; pixels_per_frame = 32'd0;

    // wvalid toggling every cycle during a burst
    base = n_starts;
    fork
      begin
        for (int i = 0; i < 8; i++) push(32'h400 + i);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1 wvalid = ~wvalid;
        end
      end
    join
    @(posedge clk); #1 wvalid = 1'b1;
    drain();
    chk("t6_starts", n_starts - base, 32'd1);
`ifdef SER_STATS_EN
    chk("t6_stall_seen", {31'd0, stall_seen}, 32'd1);
    chk("t6_burst_count", burst_count, n_starts);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wiener_block_burst_serializer.md
Name: wiener_block_burst_serializer

Overview:
- Sits directly upstream of memory_writer_output; drives its start_write_in and data_in.
- Accepts filtered pixels from the Wiener stage over an AXI-stream slave, one pixel per beat, and buffers them in a FIFO.
- Re-emits the pixels as BLOCK_SIZE-pixel write bursts, each with a start pulse, fixed setup gap and per-beat advance on wvalid, matching memory_writer_output's burst protocol.
- Tracks frame progress and flags frame completion.

Parameters:
- DATA_WIDTH, 32, width of pixel word on stream and data_out.
- BLOCK_SIZE, 8, pixels per write burst.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ BLOCK_SIZE.
- SETUP_CYCLES, 4, idle cycles between start pulse and first data beat; ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pixels_per_frame  in  32  pixels per frame; multiple of BLOCK_SIZE; sampled in IDLE only.
- s_axis_tdata  in  DATA_WIDTH  pixel from Wiener stage.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tready  out  1  FIFO can accept.
- wvalid  in  1  AXI write-data beat accepted downstream; advances burst.
- start_write_out  out  1  one-cycle burst start pulse to memory_writer_output.start_write_in.
- data_out  out  DATA_WIDTH  current burst pixel to memory_writer_output.data_in.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after last pixel of a frame is popped.

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; pointers, counters cleared; s_axis_tready=0 during reset, 1 the first cycle after; start_write_out=0, data_out=0, busy=0, frame_done=0. Reset mid-burst discards FIFO contents and partial burst.
- FIFO: push when s_axis_tvalid && s_axis_tready. s_axis_tready = (count < FIFO_DEPTH). Pop only in BURST when wvalid=1. Push and pop in the same cycle leave count unchanged; a push is allowed when full only if none happens (tready=0 when full, no bypass). Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if count ≥ BLOCK_SIZE -> START.
  - START: start_write_out=1 for exactly this cycle; setup counter loaded; -> SETUP.
  - SETUP: stay SETUP_CYCLES cycles; start_write_out=0; -> BURST.
  - BURST: data_out = FIFO head (combinational from storage, registered pointer). Each wvalid=1 cycle pops one entry and increments beat counter. After BLOCK_SIZE pops -> IDLE. wvalid=0 holds data_out and state indefinitely.
- Start-to-first-beat latency: first data beat presented SETUP_CYCLES+1 cycles after the start pulse cycle (start at T, data valid from T+SETUP_CYCLES+1).
- Outside BURST, data_out holds its last value (0 after reset).
- Back-to-back: if count ≥ BLOCK_SIZE on the cycle BURST exits, IDLE lasts exactly 1 cycle before START.
- Frame counter (32-bit) counts pops. When it reaches pixels_per_frame: frame_done=1 on the next cycle and the counter clears. pixels_per_frame=0 disables frame_done.
- Pops never exceed BLOCK_SIZE per burst; BURST is entered only with ≥ BLOCK_SIZE entries, so underflow is impossible by construction.

Optional Feature:
- Macro SER_STATS_EN.
- Defined: adds outputs burst_count[31:0] (increments on each START, saturates at all-ones, cleared by reset) and stall_seen (sticky; set when wvalid=0 for any cycle in BURST, cleared by reset).
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Push 8 pixels 0x2E,0x12,0xFD,0xB4,0x7C,0x60,0x58,0x31 with wvalid tied 1 -> one start pulse; data_out shows the same values in order on the 8 cycles starting 5 cycles after the pulse; busy drops after the 8th pop.
- Push 7 pixels only -> no start pulse, busy=0, count stays 7. Push an 8th -> START next cycle.
- Hold wvalid=0 during BURST and stream 20 pixels -> s_axis_tready falls after the 16th accepted pixel. Release wvalid -> remaining bursts drain in order, no loss or duplication.
- pixels_per_frame=256, stream the 256-pixel test image, wvalid=1 -> 32 start pulses and a single frame_done one cycle after the 256th pop; a second frame yields a second frame_done.
- Assert rst_n=0 mid-burst at beat 3 -> outputs return to reset values immediately. After release, 8 new pixels produce a fresh burst with no stale data.
- Toggle wvalid 1/0 each cycle during a burst -> data_out advances only on wvalid=1 cycles; with SER_STATS_EN, stall_seen=1 and burst_count increments by 1.
